// File: rtl/uart_cmd_decoder_pkg.sv
// Shared command encodings, ASCII constants and FSM states for the UART command decoder.
// The game engine imports this package to interpret o_cmd.
package uart_cmd_decoder_pkg;

  localparam logic [2:0] CMD_UP      = 3'd0;
  localparam logic [2:0] CMD_DOWN    = 3'd1;
  localparam logic [2:0] CMD_LEFT    = 3'd2;
  localparam logic [2:0] CMD_RIGHT   = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  localparam logic [7:0] ASCII_ESC    = 8'h1B;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_O      = 8'h4F;
  localparam logic [7:0] ASCII_A      = 8'h41;
  localparam logic [7:0] ASCII_B      = 8'h42;
  localparam logic [7:0] ASCII_C      = 8'h43;
  localparam logic [7:0] ASCII_D      = 8'h44;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ESC1 = 2'd1;
  localparam logic [1:0] ST_ESC2 = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [2:0] cmd;
  } key_t;

  // Plain keystroke map used in IDLE and when ESC1 reprocesses a byte.
  function automatic key_t key_decode(input logic [7:0] b);
    key_t k;
    k.hit = 1'b1;
    k.cmd = CMD_UP;
    case (b)
      8'h77, 8'h57, 8'h6B: k.cmd = CMD_UP;      // w W k
      8'h73, 8'h53, 8'h6A: k.cmd = CMD_DOWN;    // s S j
      8'h61, 8'h41, 8'h68: k.cmd = CMD_LEFT;    // a A h
      8'h64, 8'h44, 8'h6C: k.cmd = CMD_RIGHT;   // d D l
      8'h72, 8'h52:        k.cmd = CMD_RESTART; // r R
      default:             k.hit = 1'b0;
    endcase
    return k;
  endfunction

  // Final byte of an ANSI arrow sequence.
  function automatic key_t arrow_decode(input logic [7:0] b);
    key_t k;
    k.hit = 1'b1;
    k.cmd = CMD_UP;
    case (b)
      ASCII_A: k.cmd = CMD_UP;
      ASCII_B: k.cmd = CMD_DOWN;
      ASCII_C: k.cmd = CMD_RIGHT;
      ASCII_D: k.cmd = CMD_LEFT;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/uart_cmd_slot.sv
// One-entry valid/ready command holding register with a saturating count of
// commands discarded because the slot was full and not being drained.
module uart_cmd_slot #(
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [2:0]        load_cmd,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  output logic [DROP_W-1:0] drop_cnt
);

  logic              valid_q, valid_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    drop_d  = drop_q;
    if (load_valid) begin
      // A draining slot can take the new command in the same cycle.
      if (!valid_q || cmd_ready) begin
        valid_d = 1'b1;
        cmd_d   = load_cmd;
      end else if (drop_q != {DROP_W{1'b1}}) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      cmd_q   <= 3'd0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd       = cmd_q;
  assign drop_cnt  = drop_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes received UART bytes (WASD, HJKL, ANSI arrows, restart) into 2048 game
// commands, presented one at a time on a valid/ready interface.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned ESC_TIMEOUT = 1000000,
  parameter int unsigned DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_cmd_valid,
  output logic [2:0]        o_cmd,
  input  logic              i_cmd_ready,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_esc_err
);

  localparam int unsigned TW = $clog2(ESC_TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(ESC_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          dec_valid;
  logic [2:0]    dec_cmd;
  key_t          key, arrow;

  assign key   = key_decode(i_rx_data);
  assign arrow = arrow_decode(i_rx_data);

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    err_d     = 1'b0;
    dec_valid = 1'b0;
    dec_cmd   = key.cmd;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == ASCII_ESC) begin
            state_d = ST_ESC1;
          end else begin
            dec_valid = key.hit;
          end
        end
      end
      ST_ESC1: begin
        if (i_rx_valid) begin
          if (i_rx_data == ASCII_LBRACK || i_rx_data == ASCII_O) begin
            state_d = ST_ESC2;
          end else if (i_rx_data != ASCII_ESC) begin
            // Abandon the sequence but still honour the byte as a plain key.
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            dec_valid = key.hit;
          end
        end else if (timer_q == TIMER_MAX) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ESC2: begin
        if (i_rx_valid) begin
          if (i_rx_data == ASCII_ESC) begin
            state_d = ST_ESC1;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            err_d     = !arrow.hit;
            dec_valid = arrow.hit;
            dec_cmd   = arrow.cmd;
          end
        end else if (timer_q == TIMER_MAX) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign o_esc_err = err_q;

  uart_cmd_slot #(
    .DROP_W(DROP_W)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load_valid(dec_valid),
    .load_cmd  (dec_cmd),
    .cmd_ready (i_cmd_ready),
    .cmd_valid (o_cmd_valid),
    .cmd       (o_cmd),
    .drop_cnt  (o_drop_cnt)
  );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a per-cycle vector table plus hand-written
// sequences for escape timeout, drop saturation and reset mid-sequence.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int unsigned TO = 16;
  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [DW-1:0] drop_cnt;
  logic          esc_err;

  int checks = 0;
  int passes = 0;

  uart_cmd_decoder #(
    .ESC_TIMEOUT(TO),
    .DROP_W     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_cmd_valid(cmd_valid),
    .o_cmd      (cmd),
    .i_cmd_ready(cmd_ready),
    .o_drop_cnt (drop_cnt),
    .o_esc_err  (esc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       ev;
    logic [2:0] ecmd;
    logic       eerr;
    logic [1:0] edrop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic rdy);
    rx_valid  = v;
    rx_data   = d;
    cmd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [2:0] ecmd,
                            input logic eerr, input logic [1:0] edrop);
    check({tag, " valid"}, 32'(cmd_valid), 32'(ev));
    if (ev) check({tag, " cmd"}, 32'(cmd), 32'(ecmd));
    check({tag, " err"}, 32'(esc_err), 32'(eerr));
    check({tag, " drop"}, 32'(drop_cnt), 32'(edrop));
  endtask

  initial begin
    //                v     data   rdy   valid cmd          err   drop
    vecs.push_back('{1'b1, 8'h77, 1'b1, 1'b1, CMD_UP,      1'b0, 2'd0}); // w
    vecs.push_back('{1'b1, 8'h44, 1'b1, 1'b1, CMD_RIGHT,   1'b0, 2'd0}); // D, full slot drains
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h1B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0}); // ESC [ A
    vecs.push_back('{1'b1, 8'h5B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h41, 1'b1, 1'b1, CMD_UP,      1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h1B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0}); // ESC O C
    vecs.push_back('{1'b1, 8'h4F, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h43, 1'b1, 1'b1, CMD_RIGHT,   1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h1B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0}); // ESC a
    vecs.push_back('{1'b1, 8'h61, 1'b1, 1'b1, CMD_LEFT,    1'b1, 2'd0});
    vecs.push_back('{1'b1, 8'h1B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0}); // ESC [ Z
    vecs.push_back('{1'b1, 8'h5B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, CMD_UP,      1'b1, 2'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0});
    vecs.push_back('{1'b1, 8'h0D, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0}); // CR ignored
    vecs.push_back('{1'b1, 8'h31, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd0}); // '1' ignored
    vecs.push_back('{1'b1, 8'h73, 1'b0, 1'b1, CMD_DOWN,    1'b0, 2'd0}); // s, ready low
    vecs.push_back('{1'b1, 8'h61, 1'b0, 1'b1, CMD_DOWN,    1'b0, 2'd1}); // a dropped
    vecs.push_back('{1'b1, 8'h72, 1'b0, 1'b1, CMD_DOWN,    1'b0, 2'd2}); // r dropped
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, CMD_DOWN,    1'b0, 2'd2}); // DOWN taken
    vecs.push_back('{1'b1, 8'h52, 1'b1, 1'b1, CMD_RESTART, 1'b0, 2'd2}); // R
    vecs.push_back('{1'b1, 8'h1B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd2}); // ESC [ ESC O D
    vecs.push_back('{1'b1, 8'h5B, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd2});
    vecs.push_back('{1'b1, 8'h1B, 1'b1, 1'b0, CMD_UP,      1'b1, 2'd2});
    vecs.push_back('{1'b1, 8'h4F, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd2});
    vecs.push_back('{1'b1, 8'h44, 1'b1, 1'b1, CMD_LEFT,    1'b0, 2'd2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, CMD_UP,      1'b0, 2'd2});

    do_reset();
    check_outs("reset", 1'b0, 3'd0, 1'b0, 2'd0);
    check("reset cmd", 32'(cmd), 32'd0);

    foreach (vecs[i]) begin
      tick(vecs[i].v, vecs[i].d, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ecmd, vecs[i].eerr, vecs[i].edrop);
    end

    // Escape timeout: ESC, then TO idle cycles; error fires on the last one.
    do_reset();
    tick(1'b1, 8'h1B, 1'b1);
    for (int k = 1; k <= int'(TO); k++) begin
      tick(1'b0, 8'h00, 1'b1);
      check($sformatf("timeout err idle%0d", k), 32'(esc_err), (k == int'(TO)) ? 32'd1 : 32'd0);
    end
    tick(1'b1, 8'h5B, 1'b1);
    check_outs("to lbrack", 1'b0, 3'd0, 1'b0, 2'd0);
    tick(1'b1, 8'h41, 1'b1);
    check_outs("to A as key", 1'b1, CMD_LEFT, 1'b0, 2'd0);

    // A byte arriving in the timeout cycle beats the timeout.
    do_reset();
    tick(1'b1, 8'h1B, 1'b1);
    for (int k = 1; k < int'(TO); k++) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h5B, 1'b1);
    check_outs("edge lbrack", 1'b0, 3'd0, 1'b0, 2'd0);
    tick(1'b1, 8'h41, 1'b1);
    check_outs("edge arrow", 1'b1, CMD_UP, 1'b0, 2'd0);

    // Drop counter saturation with the engine stalled.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, (k % 2 == 1) ? 8'h77 : 8'h64, 1'b0);
      check_outs($sformatf("sat%0d", k), 1'b1, CMD_UP, 1'b0, (k - 1 > 3) ? 2'd3 : 2'(k - 1));
    end

    // Reset mid ESC2 with a pending command discards everything.
    tick(1'b1, 8'h1B, 1'b0);
    tick(1'b1, 8'h5B, 1'b0);
    rst = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    check_outs("rst mid", 1'b0, 3'd0, 1'b0, 2'd0);
    check("rst mid cmd", 32'(cmd), 32'd0);
    tick(1'b0, 8'h00, 1'b1);
    check_outs("rst after", 1'b0, 3'd0, 1'b0, 2'd0);
    tick(1'b1, 8'h41, 1'b1);
    check_outs("rst idle A", 1'b1, CMD_LEFT, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
